// File: rtl/bridge_mc.sv
// bridge_mc: single-master bridge that routes CPU accesses either to DRAM or
// to one of NSLOT memory-mapped peripheral slots on a dedicated 4 KiB page.
// Optional build macro BRIDGE_TIMEOUT_EN adds a peripheral wait timeout
// (TIMEOUT cycles). Without it, a peripheral that never answers stalls the bridge.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for req_from_cpu; the only state that samples it
// DRAM_WAIT | counting down the DRAM read latency
// PERI_WAIT | slot selected, waiting for its ready (or the timeout)
// RESP      | one-cycle ack to the CPU with err/rdata

module bridge_mc #(
    parameter int          NSLOT     = 6,
    parameter logic [19:0] PERI_PAGE = 20'hFFFFF,
    parameter int          SLOT_LSB  = 4,
    parameter int          DRAM_LAT  = 1,
    parameter int          TIMEOUT   = 255
) (
    input  logic                  clk_from_cpu,
    input  logic                  rst_n_from_cpu,
    input  logic                  req_from_cpu,
    input  logic [31:0]           addr_from_cpu,
    input  logic                  we_from_cpu,
    input  logic [31:0]           wdata_from_cpu,
    output logic                  ack_to_cpu,
    output logic                  err_to_cpu,
    output logic [31:0]           rdata_to_cpu,
    output logic [31:0]           addr_to_dram,
    output logic                  we_to_dram,
    output logic [31:0]           wdata_to_dram,
    input  logic [31:0]           rdata_from_dram,
    output logic [NSLOT-1:0]      sel_to_per,
    output logic                  we_to_per,
    output logic [31:0]           addr_to_per,
    output logic [31:0]           wdata_to_per,
    input  logic [NSLOT*32-1:0]   rdata_from_per,
    input  logic [NSLOT-1:0]      ready_from_per
);

    // Reject parameter values the datapath widths cannot represent.
    if (NSLOT < 1 || NSLOT > 16) begin : g_bad_nslot
        $error("bridge_mc: NSLOT must be 1..16");
    end
    if (DRAM_LAT < 1 || DRAM_LAT > 7) begin : g_bad_dram_lat
        $error("bridge_mc: DRAM_LAT must be 1..7");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bridge_mc: TIMEOUT must be 1..65535");
    end

    localparam logic [2:0]  DRAM_LAST = 3'(DRAM_LAT - 1);
    localparam logic [31:0] ERR_DATA  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAM_WAIT = 2'd1,
        PERI_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        addr_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [2:0]         dram_cnt;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [NSLOT-1:0]   sel_q;
    logic               we_per_q;
    logic               we_dram_q;
`ifdef BRIDGE_TIMEOUT_EN
    logic [15:0]        tmo_cnt;
    logic               tmo_hit;
`endif

    logic [7:0]         slot_idx;
    logic               is_peri;
    logic               slot_ok;
    logic [NSLOT-1:0]   sel_dec;
    logic [31:0]        per_rdata;
    logic               per_ready;

    assign slot_idx = addr_from_cpu[SLOT_LSB+7:SLOT_LSB];

    // Address decode of the incoming request: DRAM, valid slot, or decode error.
    always_comb begin
        is_peri = (addr_from_cpu[31:12] == PERI_PAGE);
        slot_ok = 1'b0;
        sel_dec = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_idx == 8'(i)) begin
                sel_dec[i] = 1'b1;
                slot_ok    = 1'b1;
            end
        end
    end

    // Read data and ready of the currently selected slot (sel_q is one-hot).
    always_comb begin
        per_rdata = '0;
        per_ready = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (sel_q[i]) begin
                per_rdata = rdata_from_per[32*i +: 32];
                per_ready = ready_from_per[i];
            end
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));
`endif

    // State register.
    always_ff @(posedge clk_from_cpu or negedge rst_n_from_cpu) begin
        if (!rst_n_from_cpu) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_from_cpu) begin
                    if (!is_peri) begin
                        state_nxt = DRAM_WAIT;
                    end else if (slot_ok) begin
                        state_nxt = PERI_WAIT;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            DRAM_WAIT: begin
                if (dram_cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            PERI_WAIT: begin
                if (per_ready) begin
                    state_nxt = RESP;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latches, downstream strobes and response capture.
    always_ff @(posedge clk_from_cpu or negedge rst_n_from_cpu) begin
        if (!rst_n_from_cpu) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            dram_cnt  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            we_per_q  <= 1'b0;
            we_dram_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            // DRAM write strobe lives for exactly the cycle after acceptance.
            we_dram_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_from_cpu) begin
                        addr_q  <= addr_from_cpu;
                        we_q    <= we_from_cpu;
                        wdata_q <= wdata_from_cpu;
                        err_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (!is_peri) begin
                            we_dram_q <= we_from_cpu;
                            dram_cnt  <= DRAM_LAST;
                        end else if (slot_ok) begin
                            sel_q    <= sel_dec;
                            we_per_q <= we_from_cpu;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= ERR_DATA;
                        end
                    end
                end
                DRAM_WAIT: begin
                    if (dram_cnt == 3'd0) begin
                        rdata_q <= we_q ? 32'd0 : rdata_from_dram;
                    end else begin
                        dram_cnt <= dram_cnt - 3'd1;
                    end
                end
                PERI_WAIT: begin
                    if (per_ready) begin
                        rdata_q  <= we_q ? 32'd0 : per_rdata;
                        sel_q    <= '0;
                        we_per_q <= 1'b0;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rdata_q  <= ERR_DATA;
                        err_q    <= 1'b1;
                        sel_q    <= '0;
                        we_per_q <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign ack_to_cpu    = (state == RESP);
    assign err_to_cpu    = (state == RESP) && err_q;
    assign rdata_to_cpu  = rdata_q;
    assign addr_to_dram  = addr_q;
    assign we_to_dram    = we_dram_q;
    assign wdata_to_dram = wdata_q;
    assign sel_to_per    = sel_q;
    assign we_to_per     = we_per_q;
    assign addr_to_per   = addr_q;
    assign wdata_to_per  = wdata_q;

endmodule

// File: tb/tb_bridge_mc.sv
// Testbench for bridge_mc: directed and randomized accesses, scoreboard of
// expected responses checked by an independent ack monitor.
module tb_bridge_mc;

    localparam int NSLOT    = 6;
    localparam int SLOT_LSB = 4;
    localparam int DRAM_LAT = 2;
    localparam int TIMEOUT  = 8;
    localparam int NEVER    = 100000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req;
    logic [31:0]          addr;
    logic                 we;
    logic [31:0]          wdata;
    logic                 ack;
    logic                 err;
    logic [31:0]          rdata;
    logic [31:0]          addr_to_dram;
    logic                 we_to_dram;
    logic [31:0]          wdata_to_dram;
    logic [31:0]          rdata_from_dram;
    logic [NSLOT-1:0]     sel_to_per;
    logic                 we_to_per;
    logic [31:0]          addr_to_per;
    logic [31:0]          wdata_to_per;
    logic [NSLOT*32-1:0]  rdata_from_per;
    logic [NSLOT-1:0]     ready_from_per;
    logic [31:0]          per_data [NSLOT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          c0;
    } exp_t;

    exp_t exp_q[$];

    bridge_mc #(
        .NSLOT(NSLOT), .PERI_PAGE(20'hFFFFF), .SLOT_LSB(SLOT_LSB),
        .DRAM_LAT(DRAM_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_from_cpu(clk), .rst_n_from_cpu(rst_n),
        .req_from_cpu(req), .addr_from_cpu(addr), .we_from_cpu(we),
        .wdata_from_cpu(wdata), .ack_to_cpu(ack), .err_to_cpu(err),
        .rdata_to_cpu(rdata), .addr_to_dram(addr_to_dram),
        .we_to_dram(we_to_dram), .wdata_to_dram(wdata_to_dram),
        .rdata_from_dram(rdata_from_dram), .sel_to_per(sel_to_per),
        .we_to_per(we_to_per), .addr_to_per(addr_to_per),
        .wdata_to_per(wdata_to_per), .rdata_from_per(rdata_from_per),
        .ready_from_per(ready_from_per)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        rdata_from_per = '0;
        for (int i = 0; i < NSLOT; i++) rdata_from_per[32*i +: 32] = per_data[i];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour: what the CPU should see for one access, given the
    // data the downstream side offers and the cycle at which the slot answers.
    function automatic exp_t model(input logic [31:0] a, input logic w,
                                   input logic [31:0] dd, input int d);
        exp_t e;
        int   idx;
        e.c0 = 0;
        idx  = int'(a[SLOT_LSB +: 8]);
        if (a[31:12] != 20'hFFFFF) begin
            e.err = 1'b0; e.rdata = w ? 32'd0 : dd; e.lat = DRAM_LAT + 1;
        end else if (idx < NSLOT) begin
            e.err = 1'b0; e.rdata = w ? 32'd0 : per_data[idx]; e.lat = d + 1;
`ifdef BRIDGE_TIMEOUT_EN
            if (d > TIMEOUT) begin
                e.err = 1'b1; e.rdata = 32'hFFFF_FFFF; e.lat = TIMEOUT + 1;
            end
`endif
        end else begin
            e.err = 1'b1; e.rdata = 32'hFFFF_FFFF; e.lat = 1;
        end
        return e;
    endfunction

    // Unselected slots get random ready noise; the selected slot gets 'on'.
    task automatic drive_ready(input bit peri, input int idx, input bit on);
        ready_from_per = NSLOT'($urandom);
        if (peri) ready_from_per[idx] = on;
    endtask

    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [31:0] dd, input int d);
        exp_t             e;
        bit               peri;
        bit               got;
        int               idx;
        int               deff;
        logic [NSLOT-1:0] oh;
        @(negedge clk);
        rdata_from_dram = dd;
        for (int i = 0; i < NSLOT; i++) per_data[i] = $urandom;
        idx  = int'(a[SLOT_LSB +: 8]);
        peri = (a[31:12] == 20'hFFFFF) && (idx < NSLOT);
        oh   = '0;
        if (peri) oh[idx] = 1'b1;
        deff = d;
`ifdef BRIDGE_TIMEOUT_EN
        if (deff > TIMEOUT) deff = TIMEOUT;
`endif
        req = 1'b1; addr = a; we = w; wdata = wd;
        drive_ready(peri, idx, 1'b0);
        e = model(a, w, dd, d);
        @(posedge clk);
        #1;
        e.c0 = cyc;
        exp_q.push_back(e);
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("sel_first", 32'(sel_to_per), 32'(oh));
                chk("we_per_first", 32'(we_to_per), peri ? 32'(w) : 32'd0);
                chk("addr_latched", addr_to_per, a);
                chk("wdata_latched", wdata_to_dram, wd);
                if (!peri && a[31:12] != 20'hFFFFF)
                    chk("we_dram_first", 32'(we_to_dram), 32'(w));
            end
            if (ack) begin
                got = 1'b1;
            end else begin
                if (k > 1 && peri && k <= deff) begin
                    chk("sel_hold", 32'(sel_to_per), 32'(oh));
                    chk("we_per_hold", 32'(we_to_per), 32'(w));
                end
                if (k > 1) chk("we_dram_pulse", 32'(we_to_dram), 32'd0);
                drive_ready(peri, idx, k >= d);
            end
        end
        req = 1'b0;
        ready_from_per = '0;
        if (!got) begin
            chk("ack_wait", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            chk("ack_single", 32'(ack), 32'd0);
            chk("rdata_hold", rdata, e.rdata);
            chk("sel_after", 32'(sel_to_per), 32'd0);
        end
    endtask

    // Peripheral read whose slot never answers; returns after 'wait_cyc' wait
    // cycles with the request still outstanding.
    task automatic start_stuck_read(input logic [31:0] a, input int wait_cyc, output bit saw_ack);
        @(negedge clk);
        for (int i = 0; i < NSLOT; i++) per_data[i] = $urandom;
        req = 1'b1; addr = a; we = 1'b0; wdata = $urandom;
        drive_ready(1'b1, int'(a[SLOT_LSB +: 8]), 1'b0);
        @(posedge clk);
        saw_ack = 1'b0;
        for (int k = 1; k <= wait_cyc; k++) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
            drive_ready(1'b1, int'(a[SLOT_LSB +: 8]), 1'b0);
        end
    endtask

    task automatic apply_reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(sel_to_per), 32'd0);
        chk("rst_we_per", 32'(we_to_per), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", addr_to_per, 32'd0);
        req = 1'b0;
        ready_from_per = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every ack pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_err", 32'(err), 32'(e.err));
                        chk("ack_rdata", rdata, e.rdata);
                        chk("ack_latency", 32'(cyc - e.c0 + 1), 32'(e.lat));
                    end
                end else begin
                    chk("err_outside_ack", 32'(err), 32'd0);
                end
            end
        end
    end

    initial begin
        bit          saw;
        logic [31:0] a;
        int          kind;
        rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; wdata = '0;
        rdata_from_dram = '0; ready_from_per = '0;
        for (int i = 0; i < NSLOT; i++) per_data[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_sel", 32'(sel_to_per), 32'd0);
        chk("reset_we_dram", 32'(we_to_dram), 32'd0);
        chk("reset_addr_dram", addr_to_dram, 32'd0);
        rst_n = 1'b1;

        do_txn(32'h0000_0100, 1'b0, 32'h0, 32'h1234_5678, 0);
        do_txn(32'hFFFF_F020, 1'b1, 32'h0000_00A5, $urandom, 3);
        do_txn(32'hFFFF_F0F0, 1'b0, $urandom, $urandom, 1);
        do_txn(32'hFFFF_F000, 1'b0, $urandom, $urandom, 1);
        do_txn(32'hFFFF_F050, 1'b0, $urandom, $urandom, 2);
        do_txn(32'hFFFF_F060, 1'b1, $urandom, $urandom, 1);
        do_txn(32'hFFFF_EFFC, 1'b1, $urandom, $urandom, 0);
        do_txn(32'hFFFF_EFFC, 1'b0, $urandom, $urandom, 0);
        do_txn(32'hFFFF_F040, 1'b0, $urandom, $urandom, TIMEOUT);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            if (kind == 0) begin
                if (a[31:12] == 20'hFFFFF) a[12] = 1'b0;
            end else if (kind == 1) begin
                a = {20'hFFFFF, 8'($urandom_range(0, NSLOT - 1)), a[3:0]};
            end else begin
                a = {20'hFFFFF, 8'($urandom_range(NSLOT, 255)), a[3:0]};
            end
            do_txn(a, 1'($urandom), $urandom, $urandom, int'($urandom_range(1, 5)));
        end

`ifdef BRIDGE_TIMEOUT_EN
        do_txn(32'hFFFF_F010, 1'b0, $urandom, $urandom, NEVER);
        do_txn(32'hFFFF_F010, 1'b1, $urandom, $urandom, NEVER);
`else
        start_stuck_read(32'hFFFF_F010, 1000, saw);
        chk("no_ack_1000", 32'(saw), 32'd0);
        chk("stuck_sel", 32'(sel_to_per), 32'h2);
        @(negedge clk);
        apply_reset_now();
`endif

        start_stuck_read(32'hFFFF_F030, 1, saw);
        chk("mid_sel", 32'(sel_to_per), 32'h8);
        @(negedge clk);
        apply_reset_now();
        chk("mid_no_ack", 32'(saw), 32'd0);
        do_txn(32'h0000_0100, 1'b0, 32'h0, 32'hCAFE_F00D, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "tb_bridge_mc time limit");
    end

endmodule
